// File: rtl/tour_cmd.sv
// Replays a solved knight's tour as pairs of vertical/horizontal move commands,
// and passes UART commands straight through to the command processor when idle.
module tour_cmd #(
    parameter int LAST_INDX = 23
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    output logic        clr_cmd_rdy_UART,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [7:0]  resp
);

    localparam logic [4:0] LAST      = 5'(LAST_INDX);
    localparam logic [3:0] OP_MOVE   = 4'b0010;
    localparam logic [3:0] OP_FANF   = 4'b0011;
    localparam logic [7:0] HDG_NORTH = 8'h00;
    localparam logic [7:0] HDG_WEST  = 8'h3F;
    localparam logic [7:0] HDG_SOUTH = 8'h7F;
    localparam logic [7:0] HDG_EAST  = 8'hBF;
    localparam logic [7:0] RESP_ACK  = 8'hA5;
    localparam logic [7:0] RESP_DONE = 8'h5A;

    typedef enum logic [2:0] {IDLE, VERT, HOLD_V, HORZ, HOLD_H} state_t;
    state_t state;

    logic signed [2:0] dx;
    logic signed [2:0] dy;
    logic              no_move;
    logic [15:0]       vert_cmd;
    logic [15:0]       horz_cmd;
    logic              at_last;

    function automatic logic [3:0] mag(input logic signed [2:0] v);
        return (v < 3'sd0) ? 4'(-v) : 4'(v);
    endfunction

    // Lowest set bit of a multi-hot move takes priority.
    always_comb begin
        dx = 3'sd0;
        dy = 3'sd0;
        if      (move[0]) begin dx =  3'sd1; dy =  3'sd2; end
        else if (move[1]) begin dx = -3'sd1; dy =  3'sd2; end
        else if (move[2]) begin dx = -3'sd2; dy =  3'sd1; end
        else if (move[3]) begin dx = -3'sd2; dy = -3'sd1; end
        else if (move[4]) begin dx = -3'sd1; dy = -3'sd2; end
        else if (move[5]) begin dx =  3'sd1; dy = -3'sd2; end
        else if (move[6]) begin dx =  3'sd2; dy = -3'sd1; end
        else if (move[7]) begin dx =  3'sd2; dy =  3'sd1; end
    end

    assign no_move = (move == 8'h00);
    assign at_last = (mv_indx == LAST);

    // An empty move still issues two zero-length legs facing north.
    assign vert_cmd = {OP_MOVE,
                       (no_move || dy > 3'sd0) ? HDG_NORTH : HDG_SOUTH,
                       mag(dy)};
    assign horz_cmd = {OP_FANF,
                       no_move ? HDG_NORTH : ((dx > 3'sd0) ? HDG_EAST : HDG_WEST),
                       mag(dx)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mv_indx <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_tour) begin
                        mv_indx <= 5'd0;
                        state   <= VERT;
                    end
                end
                VERT:   if (clr_cmd_rdy) state <= HOLD_V;
                HOLD_V: if (send_resp)   state <= HORZ;
                HORZ:   if (clr_cmd_rdy) state <= HOLD_H;
                HOLD_H: begin
                    if (send_resp) begin
                        if (at_last) begin
                            state <= IDLE;
                        end else begin
                            mv_indx <= mv_indx + 5'd1;
                            state   <= VERT;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // While a tour is running the UART side is fenced off completely.
    always_comb begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        resp             = RESP_DONE;
        case (state)
            VERT: begin
                cmd              = vert_cmd;
                cmd_rdy          = 1'b1;
                clr_cmd_rdy_UART = 1'b0;
                resp             = RESP_ACK;
            end
            HOLD_V: begin
                cmd              = vert_cmd;
                cmd_rdy          = 1'b0;
                clr_cmd_rdy_UART = 1'b0;
                resp             = RESP_ACK;
            end
            HORZ: begin
                cmd              = horz_cmd;
                cmd_rdy          = 1'b1;
                clr_cmd_rdy_UART = 1'b0;
                resp             = RESP_ACK;
            end
            HOLD_H: begin
                cmd              = horz_cmd;
                cmd_rdy          = 1'b0;
                clr_cmd_rdy_UART = 1'b0;
                resp             = at_last ? RESP_DONE : RESP_ACK;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tour_cmd.sv
// Directed plus randomized-tour bench for tour_cmd against a move-table reference model.
module tb_tour_cmd;

    localparam int LAST = 23;
    localparam int DX[8] = '{1, -1, -2, -2, -1, 1, 2, 2};
    localparam int DY[8] = '{2, 2, 1, -1, -2, -2, -1, 1};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_tour = 1'b0;
    logic [7:0]  move;
    logic [7:0]  move_drv = 8'h00;
    logic [4:0]  mv_indx;
    logic [15:0] cmd_UART = 16'h0000;
    logic        cmd_rdy_UART = 1'b0;
    logic        clr_cmd_rdy_UART;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic        send_resp = 1'b0;
    logic [7:0]  resp;

    logic        use_table = 1'b0;
    logic [7:0]  tour_moves [32];
    int          tests = 0;
    int          fails = 0;
    int          cmds_seen = 0;

    tour_cmd #(.LAST_INDX(LAST)) dut (
        .clk(clk), .rst_n(rst_n), .start_tour(start_tour), .move(move),
        .mv_indx(mv_indx), .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART),
        .clr_cmd_rdy_UART(clr_cmd_rdy_UART), .cmd(cmd), .cmd_rdy(cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .resp(resp)
    );

    always #5 clk = ~clk;

    // The solver presents the move for whatever index the DUT is replaying.
    always_comb move = use_table ? tour_moves[mv_indx] : move_drv;

    function automatic logic [15:0] exp_leg(input logic [7:0] m, input bit horiz);
        int  dx = 0;
        int  dy = 0;
        bit  found = 0;
        for (int i = 0; i < 8; i++) begin
            if (m[i] && !found) begin
                found = 1;
                dx = DX[i];
                dy = DY[i];
            end
        end
        if (!found) return horiz ? 16'h3000 : 16'h2000;
        if (horiz) return {4'h3, (dx > 0) ? 8'hBF : 8'h3F, 4'((dx < 0) ? -dx : dx)};
        return {4'h2, (dy > 0) ? 8'h00 : 8'h7F, 4'((dy < 0) ? -dy : dy)};
    endfunction

    function automatic logic [7:0] rand_move();
        int r = $urandom_range(0, 9);
        if (r < 7) return 8'(1 << $urandom_range(0, 7));
        if (r < 9) return 8'($urandom);
        return 8'h00;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Idle cycles with start_tour and cmd_rdy_UART toggling; both must be ignored mid-tour.
    task automatic noise();
        repeat ($urandom_range(0, 2)) begin
            start_tour   = 1'($urandom);
            cmd_rdy_UART = 1'($urandom);
            tick();
        end
        start_tour = 1'b0;
        #1;
    endtask

    task automatic run_tour(input int abort_at);
        for (int i = 0; i < 32; i++) tour_moves[i] = rand_move();
        use_table = 1'b1;
        cmds_seen = 0;
        start_tour = 1'b1;
        tick();
        start_tour = 1'b0;
        for (int k = 0; k <= LAST; k++) begin
            noise();
            check("vert_idx", 16'(mv_indx), 16'(k));
            check("vert_rdy", 16'(cmd_rdy), 16'd1);
            check("vert_cmd", cmd, exp_leg(tour_moves[k], 1'b0));
            check("vert_resp", 16'(resp), 16'h00A5);
            clr_cmd_rdy = 1'b1;
            #1;
            check("vert_clr_uart", 16'(clr_cmd_rdy_UART), 16'd0);
            if (cmd_rdy) cmds_seen++;
            tick();
            clr_cmd_rdy = 1'b0;
            noise();
            check("holdv_rdy", 16'(cmd_rdy), 16'd0);
            check("holdv_resp", 16'(resp), 16'h00A5);
            send_resp = 1'b1;
            tick();
            send_resp = 1'b0;
            noise();
            check("horz_idx", 16'(mv_indx), 16'(k));
            check("horz_rdy", 16'(cmd_rdy), 16'd1);
            check("horz_cmd", cmd, exp_leg(tour_moves[k], 1'b1));
            clr_cmd_rdy = 1'b1;
            #1;
            check("horz_clr_uart", 16'(clr_cmd_rdy_UART), 16'd0);
            if (cmd_rdy) cmds_seen++;
            tick();
            clr_cmd_rdy = 1'b0;
            noise();
            check("holdh_rdy", 16'(cmd_rdy), 16'd0);
            check("holdh_resp", 16'(resp), (k == LAST) ? 16'h005A : 16'h00A5);
            if (k == abort_at) begin
                rst_n = 1'b0;
                cmd_rdy_UART = 1'b1;
                #1;
                check("abort_idx", 16'(mv_indx), 16'd0);
                check("abort_rdy_follow1", 16'(cmd_rdy), 16'd1);
                cmd_rdy_UART = 1'b0;
                #1;
                check("abort_rdy_follow0", 16'(cmd_rdy), 16'd0);
                tick();
                rst_n = 1'b1;
                tick();
                check("post_abort_rdy", 16'(cmd_rdy), 16'd0);
                check("post_abort_resp", 16'(resp), 16'h005A);
                cmd_UART = 16'($urandom);
                cmd_rdy_UART = 1'b1;
                #1;
                check("post_abort_cmd", cmd, cmd_UART);
                check("post_abort_rdy1", 16'(cmd_rdy), 16'd1);
                cmd_rdy_UART = 1'b0;
                use_table = 1'b0;
                return;
            end
            send_resp = 1'b1;
            tick();
            send_resp = 1'b0;
        end
        cmd_UART = 16'($urandom);
        cmd_rdy_UART = 1'b1;
        #1;
        check("end_idx", 16'(mv_indx), 16'(LAST));
        check("end_resp", 16'(resp), 16'h005A);
        check("end_cmd_pass", cmd, cmd_UART);
        check("end_rdy_pass", 16'(cmd_rdy), 16'd1);
        check("end_cmd_count", 16'(cmds_seen), 16'd48);
        cmd_rdy_UART = 1'b0;
        tick();
        check("end_idx_held", 16'(mv_indx), 16'(LAST));
        use_table = 1'b0;
    endtask

    initial begin
        // Reset state, before any clock edge
        #2;
        check("rst_idx", 16'(mv_indx), 16'd0);
        check("rst_rdy", 16'(cmd_rdy), 16'd0);
        check("rst_resp", 16'(resp), 16'h005A);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // UART pass-through
        cmd_UART = 16'h2FF1;
        cmd_rdy_UART = 1'b1;
        #1;
        check("pass_cmd", cmd, 16'h2FF1);
        check("pass_rdy", 16'(cmd_rdy), 16'd1);
        check("pass_clr0", 16'(clr_cmd_rdy_UART), 16'd0);
        clr_cmd_rdy = 1'b1;
        #1;
        check("pass_clr1", 16'(clr_cmd_rdy_UART), 16'd1);
        tick();
        clr_cmd_rdy = 1'b0;
        cmd_rdy_UART = 1'b0;

        // Directed move 0x01, with out-of-place inputs that must be ignored
        move_drv = 8'h01;
        start_tour = 1'b1;
        tick();
        start_tour = 1'b0;
        cmd_rdy_UART = 1'b1;
        #1;
        check("d_vert_cmd", cmd, 16'h2002);
        check("d_vert_rdy", 16'(cmd_rdy), 16'd1);
        check("d_vert_resp", 16'(resp), 16'h00A5);
        send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
        check("d_vert_stay_cmd", cmd, 16'h2002);
        check("d_vert_stay_rdy", 16'(cmd_rdy), 16'd1);
        clr_cmd_rdy = 1'b1;
        tick();
        check("d_holdv_rdy", 16'(cmd_rdy), 16'd0);
        check("d_holdv_clr_uart", 16'(clr_cmd_rdy_UART), 16'd0);
        tick();
        clr_cmd_rdy = 1'b0;
        check("d_holdv_stay_rdy", 16'(cmd_rdy), 16'd0);
        send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
        check("d_horz_cmd", cmd, 16'h3BF1);
        check("d_horz_rdy", 16'(cmd_rdy), 16'd1);
        start_tour = 1'b1;
        tick();
        start_tour = 1'b0;
        check("d_horz_stay_cmd", cmd, 16'h3BF1);
        check("d_horz_stay_idx", 16'(mv_indx), 16'd0);
        move_drv = 8'h08;
        #1;
        check("d_horz_cmd_08", cmd, 16'h33F2);
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
        send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
        check("d_vert_cmd_08", cmd, 16'h27F1);
        check("d_next_idx", 16'(mv_indx), 16'd1);
        move_drv = 8'h00;
        #1;
        check("d_vert_cmd_zero", cmd, 16'h2000);
        move_drv = 8'hC0;
        #1;
        check("d_vert_cmd_multi", cmd, 16'h27F1);
        rst_n = 1'b0;
        cmd_rdy_UART = 1'b0;
        #1;
        check("d_rst_idx", 16'(mv_indx), 16'd0);
        check("d_rst_rdy", 16'(cmd_rdy), 16'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Randomized full tour, then one abandoned by reset at index 7
        run_tour(-1);
        tick();
        run_tour(7);
        tick();
        run_tour(-1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
